// File: rtl/fp_mul_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
//   in_valid/in_ready : operand pair handshake, a/b carry {sign, exp, frac}
//   out_valid/out_ready : result handshake, op is the product, flags are
//                        {invalid, overflow, underflow, inexact} aligned with op
// master drives operands and out_ready; slave is the multiplier.
interface fp_mul_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] op;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, op, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, op, flags
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with valid/ready handshake.
//   clk, rst : clock and synchronous active-high reset
//   bus      : fp_mul_if slave (operands in, product + flags out)
// Stages: S1 unpack/classify/exponent sum, S2 mantissa product,
// S3 normalise/round/pack/flags. Whole pipe stalls together on backpressure.
// Subnormal inputs are flushed to zero and tiny results flush to zero.
module fp_mul_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter bit          RNE   = 1'b1
) (
  input logic     clk,
  input logic     rst,
  fp_mul_if.slave bus
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam logic [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  logic adv;

  // S1 unpack and classify
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             nan_d, inf_d, zero_d;
  logic [EW-1:0]    exp_d;

  assign {sa, ea, fa} = bus.a;
  assign {sb, eb, fb} = bus.b;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign nan_d  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
  assign inf_d  = !nan_d && (a_inf || b_inf);
  assign zero_d = !nan_d && !inf_d && (a_zero || b_zero);
  // Two guard bits above the field keep overflow and negative exponents visible
  assign exp_d  = EW'(ea) + EW'(eb) - BIAS;

  logic             v1_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
  logic [EW-1:0]    s1_exp_q;
  logic [MAN_W:0]   s1_ma_q, s1_mb_q;

  logic             v2_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
  logic [EW-1:0]    s2_exp_q;
  logic [PW-1:0]    s2_prod_q;

  logic             v3_q;
  logic [W-1:0]     op_q, op_d;
  logic [3:0]       flags_q, flags_d;

  assign adv           = !v3_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3_q;
  assign bus.op        = op_q;
  assign bus.flags     = flags_q;

  // S3 normalise and round
  logic             top, guard, sticky, inc, carry, ovf, unf;
  logic [MAN_W-1:0] frac;
  logic [MAN_W:0]   frac_r;
  logic [EW-1:0]    exp_n;

  always_comb begin
    top    = s2_prod_q[PW-1];
    frac   = top ? s2_prod_q[2*MAN_W:MAN_W+1] : s2_prod_q[2*MAN_W-1:MAN_W];
    guard  = top ? s2_prod_q[MAN_W] : s2_prod_q[MAN_W-1];
    sticky = top ? |s2_prod_q[MAN_W-1:0] : |s2_prod_q[MAN_W-2:0];
    inc    = RNE && guard && (sticky || frac[0]);
    frac_r = {1'b0, frac} + (MAN_W+1)'(inc);
    // On carry-out the low bits are already zero, only the exponent bumps
    carry  = frac_r[MAN_W];
    exp_n  = s2_exp_q + EW'(top) + EW'(carry);
    ovf    = !exp_n[EW-1] && (exp_n >= EXP_MAX);
    unf    = exp_n[EW-1] || (exp_n == '0);

    op_d    = {s2_sign_q, exp_n[EXP_W-1:0], frac_r[MAN_W-1:0]};
    flags_d = {3'b000, guard || sticky};
    if (s2_nan_q) begin
      op_d    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flags_d = 4'b1000;
    end else if (s2_inf_q) begin
      op_d    = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0000;
    end else if (s2_zero_q) begin
      op_d    = {s2_sign_q, {(W-1){1'b0}}};
      flags_d = 4'b0000;
    end else if (ovf) begin
      op_d    = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (unf) begin
      op_d    = {s2_sign_q, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_nan_q  <= 1'b0;
      s1_inf_q  <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_ma_q   <= '0;
      s1_mb_q   <= '0;
      v2_q      <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_nan_q  <= 1'b0;
      s2_inf_q  <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_prod_q <= '0;
      v3_q      <= 1'b0;
      op_q      <= '0;
      flags_q   <= '0;
    end else if (adv) begin
      v1_q      <= bus.in_valid;
      s1_sign_q <= sa ^ sb;
      s1_nan_q  <= nan_d;
      s1_inf_q  <= inf_d;
      s1_zero_q <= zero_d;
      s1_exp_q  <= exp_d;
      s1_ma_q   <= {1'b1, fa};
      s1_mb_q   <= {1'b1, fb};
      v2_q      <= v1_q;
      s2_sign_q <= s1_sign_q;
      s2_nan_q  <= s1_nan_q;
      s2_inf_q  <= s1_inf_q;
      s2_zero_q <= s1_zero_q;
      s2_exp_q  <= s1_exp_q;
      s2_prod_q <= PW'(s1_ma_q) * PW'(s1_mb_q);
      v3_q      <= v2_q;
      if (v2_q) begin
        op_q    <= op_d;
        flags_q <= flags_d;
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: a round-to-nearest-even instance and a
// truncating instance share identical stimulus.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mul_if #(.EXP_W(8), .MAN_W(23)) bus ();
  fp_mul_if #(.EXP_W(8), .MAN_W(23)) bus_tz ();

  assign bus_tz.in_valid  = bus.in_valid;
  assign bus_tz.a         = bus.a;
  assign bus_tz.b         = bus.b;
  assign bus_tz.out_ready = bus.out_ready;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .RNE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .RNE(1'b0)) dut_tz (
    .clk (clk),
    .rst (rst),
    .bus (bus_tz)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] op_rne;
    logic [31:0] op_tz;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[14];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One isolated beat: accept, count edges to out_valid, check result.
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    @(negedge clk);
    bus.a        = v.a;
    bus.b        = v.b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd3);
    check({name, " op rne"}, bus.op, v.op_rne);
    check({name, " flags"}, 32'(bus.flags), 32'(v.flags));
    check({name, " op tz"}, bus_tz.out_valid ? bus_tz.op : 32'hDEADBEEF, v.op_tz);
    check({name, " flags tz"}, 32'(bus_tz.flags), 32'(v.flags));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] bp_a[6];
    logic [31:0] bp_exp[6];
    logic [31:0] held_op;
    int          tx, rx, stall, cyc;
    logic        held, stuck;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    vecs[0]  = '{32'h40400000, 32'h40200000, 32'h40F00000, 32'h40F00000, 4'b0000};
    vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 32'hBF800000, 4'b0000};
    vecs[2]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 32'h3FC00001, 4'b0001};
    vecs[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 32'h3F800002, 4'b0001};
    vecs[4]  = '{32'h3FC00001, 32'h3FC00001, 32'h40100002, 32'h40100001, 4'b0001};
    vecs[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 4'b1000};
    vecs[6]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 32'hFF800000, 4'b0000};
    vecs[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 4'b1000};
    vecs[8]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 32'h7F800000, 4'b0101};
    vecs[9]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 32'h00000000, 4'b0011};
    vecs[10] = '{32'h80000000, 32'h40400000, 32'h80000000, 32'h80000000, 4'b0000};
    vecs[11] = '{32'h00000001, 32'h3F800000, 32'h00000000, 32'h00000000, 4'b0000};
    vecs[12] = '{32'h7F800000, 32'hFF800000, 32'hFF800000, 32'hFF800000, 4'b0000};
    vecs[13] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 32'h407FFFFE, 4'b0001};

    // 1..6 times 2.0
    bp_a   = '{32'h3F800000, 32'h40000000, 32'h40400000,
               32'h40800000, 32'h40A00000, 32'h40C00000};
    bp_exp = '{32'h40000000, 32'h40800000, 32'h40C00000,
               32'h41000000, 32'h41200000, 32'h41400000};

    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset op", bus.op, 32'd0);
    check("reset flags", 32'(bus.flags), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: stall 5 cycles once the first result shows up.
    tx    = 0;
    rx    = 0;
    stall = -1;
    cyc   = 0;
    held  = 1'b0;
    held_op = '0;
    while (rx < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid && stall < 0) stall = 5;
      bus.out_ready = !(stall > 0);
      if (stall > 0) stall--;
      bus.in_valid = (tx < 6);
      bus.a        = bp_a[(tx < 6) ? tx : 0];
      bus.b        = 32'h40000000;
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        check("bp in_ready low", 32'(bus.in_ready), 32'd0);
        if (held) check("bp op held", bus.op, held_op);
        held_op = bus.op;
        held    = 1'b1;
      end else begin
        held = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) tx++;
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("bp result %0d", rx), bus.op, bp_exp[rx]);
        rx++;
      end
    end
    check("bp result count", 32'(rx), 32'd6);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp no extra result", 32'(bus.out_valid), 32'd0);

    // Reset with three items in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.a        = bp_a[i];
      bus.b        = 32'h40000000;
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("flight out_valid before rst", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst flush out_valid", 32'(bus.out_valid), 32'd0);
    check("rst flush op", bus.op, 32'd0);
    check("rst flush flags", 32'(bus.flags), 32'd0);
    stuck = 1'b0;
    repeat (5) begin
      @(negedge clk);
      stuck = stuck | bus.out_valid | bus_tz.out_valid;
    end
    check("rst stays empty", 32'(stuck), 32'd0);
    run_vec(vecs[0], "post rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
